// File: rtl/adder_stim_check_if.sv
// Stimulus/result bundle between the adder checker and the adders under test.
// The checker (master) drives {cin,a,b}; the reference adder and the DUV
// (slave side) return their sum, carry, propagate and generate results.
interface adder_stim_check_if #(
  parameter int n = 4
);
  logic         cin;
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic [n-1:0] s_ref;
  logic [n-1:0] s_duv;
  logic         cout_ref;
  logic         cout_duv;
  logic         prop_ref;
  logic         prop_duv;
  logic         gen_ref;
  logic         gen_duv;

  modport master (
    output cin, a, b,
    input  s_ref, s_duv, cout_ref, cout_duv,
    input  prop_ref, prop_duv, gen_ref, gen_duv
  );

  modport slave (
    input  cin, a, b,
    output s_ref, s_duv, cout_ref, cout_duv,
    output prop_ref, prop_duv, gen_ref, gen_duv
  );
endinterface

// File: rtl/adder_stim_check.sv
// Self-running stimulus generator and comparator for an n-bit adder DUV.
// Drives {cin,a,b} one vector per cycle to a reference adder and the DUV and
// compares their results on the edge that retires each vector.
// The exhaustive sweep is always built; define ADDER_STIM_LFSR_EN to add the
// seeded LFSR random mode (otherwise mode/seed/num_vec are ignored).
// The compare selector is called chk_type because 'type' is a reserved word:
// 0 = sum/carry only, 1 = also propagate/generate.
module adder_stim_check #(
  parameter int n        = 4,
  parameter int chk_type = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic [15:0]        num_vec,
  input  logic [31:0]        seed,
  adder_stim_check_if.master bus,
  output logic               busy,
  output logic               done,
  output logic [15:0]        err_cnt,
  output logic [2*n:0]       fail_vec,
  output logic               fail_seen
);
  localparam int W = 2 * n + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_reg;
  state_t       state_next;
  logic [W-1:0] vec_reg;
  logic [W-1:0] first_vec;
  logic [W-1:0] step_vec;
  logic         last_vec;
  logic         start_run;
  logic         mismatch;

  // start is only honoured outside RUN
  assign start_run = start && (state_reg != RUN);

  assign bus.cin = vec_reg[W-1];
  assign bus.a   = vec_reg[W-2:n];
  assign bus.b   = vec_reg[n-1:0];

`ifdef ADDER_STIM_LFSR_EN
  logic        mode_reg;
  logic [31:0] lfsr_reg;
  logic [31:0] lfsr_next;
  logic [31:0] seed_eff;
  logic [15:0] left_reg;
  logic [15:0] num_eff;

  // an all-zero LFSR would lock up, and a zero-length run makes no sense
  assign seed_eff  = (seed == 32'd0) ? 32'h1 : seed;
  assign num_eff   = (num_vec == 16'd0) ? 16'd1 : num_vec;
  // x^32+x^22+x^2+x+1, shifting left with feedback into bit 0
  assign lfsr_next = {lfsr_reg[30:0], lfsr_reg[31] ^ lfsr_reg[21] ^ lfsr_reg[1] ^ lfsr_reg[0]};

  assign first_vec = mode ? seed_eff[W-1:0] : '0;
  assign step_vec  = mode_reg ? lfsr_next[W-1:0] : vec_reg + W'(1);
  assign last_vec  = mode_reg ? (left_reg == 16'd1) : (&vec_reg);

  // random-mode sequencer: capture settings on start, step LFSR and count down in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg <= 1'b0;
      lfsr_reg <= 32'h1;
      left_reg <= 16'd0;
    end else if (start_run) begin
      mode_reg <= mode;
      lfsr_reg <= seed_eff;
      left_reg <= num_eff;
    end else if (state_reg == RUN && mode_reg) begin
      lfsr_reg <= lfsr_next;
      left_reg <= left_reg - 16'd1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{mode, num_vec, seed};
  assign first_vec  = '0;
  assign step_vec   = vec_reg + W'(1);
  // the vector itself is the sweep counter; all-ones is the final vector
  assign last_vec   = &vec_reg;
`endif

  // a vector fails if any compared result differs between reference and DUV
  always_comb begin
    mismatch = (bus.s_ref != bus.s_duv) || (bus.cout_ref != bus.cout_duv);
    if (chk_type == 1)
      mismatch = mismatch || (bus.prop_ref != bus.prop_duv) || (bus.gen_ref != bus.gen_duv);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // next-state logic: leave RUN on the edge that retires the last vector
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_vec) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // status outputs decoded from state
  always_comb begin
    busy = (state_reg == RUN);
    done = (state_reg == DONE);
  end

  // stimulus register: first vector on run start, advance while running, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      vec_reg <= '0;
    else if (start_run)
      vec_reg <= first_vec;
    else if (state_reg == RUN && !last_vec)
      vec_reg <= step_vec;
  end

  // result bookkeeping: clear on run start, count/capture mismatches only in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt   <= 16'd0;
      fail_seen <= 1'b0;
      fail_vec  <= '0;
    end else if (start_run) begin
      err_cnt   <= 16'd0;
      fail_seen <= 1'b0;
      fail_vec  <= '0;
    end else if (state_reg == RUN && mismatch) begin
      if (err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
      if (!fail_seen) begin
        fail_seen <= 1'b1;
        fail_vec  <= vec_reg;
      end
    end
  end
endmodule

// File: tb/tb_adder_stim_check.sv
// Bench for adder_stim_check: two checker instances (sum/carry only, and with
// prop/gen) drive bench-side reference/DUV adders with injectable faults.
// Define ADDER_STIM_LFSR_EN to also exercise the random mode.
`timescale 1ns/1ps
module tb_adder_stim_check;
  localparam int N  = 4;
  localparam int W  = 2 * N + 1;
  localparam int NV = 1 << W;
`ifdef ADDER_STIM_LFSR_EN
  localparam bit LFSR_ON = 1'b1;
`else
  localparam bit LFSR_ON = 1'b0;
`endif

  typedef struct {
    string        name;
    int           fault;
    bit           hold;
    int           e0_err;
    bit           e0_fs;
    logic [W-1:0] e0_fv;
    int           e1_err;
    bit           e1_fs;
    logic [W-1:0] e1_fv;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [15:0]  num_vec = 16'd0;
  logic [31:0]  seed = 32'd0;
  logic         busy0, done0, fail_seen0, busy1, done1, fail_seen1;
  logic [15:0]  err_cnt0, err_cnt1;
  logic [W-1:0] fail_vec0, fail_vec1;
  logic [NV-1:0] fault_s = '0, fault_c = '0, fault_p = '0, fault_g = '0;
  logic [W-1:0] v0, v1;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;
  int overlap = 0;
  logic [W-1:0] q0[$], q1[$], exp_q[$];
  int           m_err[2];
  bit           m_fs[2];
  logic [W-1:0] m_fv[2];

  always #5 clk = ~clk;

  adder_stim_check_if #(.n(N)) bus0 ();
  adder_stim_check_if #(.n(N)) bus1 ();

  // adders seen by instance 0
  assign v0 = {bus0.cin, bus0.a, bus0.b};
  assign {bus0.cout_ref, bus0.s_ref} = {1'b0, bus0.a} + {1'b0, bus0.b} + {{N{1'b0}}, bus0.cin};
  assign bus0.s_duv    = bus0.s_ref ^ {{(N-1){1'b0}}, fault_s[v0]};
  assign bus0.cout_duv = bus0.cout_ref ^ fault_c[v0];
  assign bus0.prop_ref = &(bus0.a ^ bus0.b);
  assign bus0.prop_duv = bus0.prop_ref ^ fault_p[v0];
  assign bus0.gen_ref  = |(bus0.a & bus0.b);
  assign bus0.gen_duv  = bus0.gen_ref ^ fault_g[v0];

  // adders seen by instance 1
  assign v1 = {bus1.cin, bus1.a, bus1.b};
  assign {bus1.cout_ref, bus1.s_ref} = {1'b0, bus1.a} + {1'b0, bus1.b} + {{N{1'b0}}, bus1.cin};
  assign bus1.s_duv    = bus1.s_ref ^ {{(N-1){1'b0}}, fault_s[v1]};
  assign bus1.cout_duv = bus1.cout_ref ^ fault_c[v1];
  assign bus1.prop_ref = &(bus1.a ^ bus1.b);
  assign bus1.prop_duv = bus1.prop_ref ^ fault_p[v1];
  assign bus1.gen_ref  = |(bus1.a & bus1.b);
  assign bus1.gen_duv  = bus1.gen_ref ^ fault_g[v1];

  adder_stim_check #(.n(N), .chk_type(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .num_vec(num_vec), .seed(seed),
    .bus(bus0), .busy(busy0), .done(done0), .err_cnt(err_cnt0),
    .fail_vec(fail_vec0), .fail_seen(fail_seen0)
  );

  adder_stim_check #(.n(N), .chk_type(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .num_vec(num_vec), .seed(seed),
    .bus(bus1), .busy(busy1), .done(done1), .err_cnt(err_cnt1),
    .fail_vec(fail_vec1), .fail_seen(fail_seen1)
  );

  // record every vector presented while busy, and any busy/done overlap
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy0) q0.push_back(v0);
      if (busy1) q1.push_back(v1);
      if ((busy0 && done0) || (busy1 && done1)) overlap++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // LFSR step written from the polynomial exponents: 32,22,2,1 -> bits 31,21,1,0
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    int          taps[4] = '{32, 22, 2, 1};
    logic        fb = 1'b0;
    foreach (taps[k]) fb = fb ^ s[taps[k]-1];
    return {s[30:0], fb};
  endfunction

  task automatic build_exp(input bit md, input logic [31:0] sd, input logic [15:0] nv);
    int          cnt;
    logic [31:0] st;
    exp_q.delete();
    if (!LFSR_ON || !md) begin
      for (int i = 0; i < NV; i++) exp_q.push_back(W'(i));
    end else begin
      cnt = (nv == 16'd0) ? 1 : int'(nv);
      st  = (sd == 32'd0) ? 32'h1 : sd;
      for (int i = 0; i < cnt; i++) begin
        exp_q.push_back(st[W-1:0]);
        st = lfsr_step(st);
      end
    end
  endtask

  task automatic model_results();
    logic [W-1:0] v;
    bit           bad[2];
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 0; m_fs[k] = 1'b0; m_fv[k] = '0;
    end
    foreach (exp_q[i]) begin
      v = exp_q[i];
      bad[0] = fault_s[v] | fault_c[v];
      bad[1] = bad[0] | fault_p[v] | fault_g[v];
      for (int k = 0; k < 2; k++) begin
        if (bad[k]) begin
          if (m_err[k] < 65535) m_err[k]++;
          if (!m_fs[k]) begin m_fs[k] = 1'b1; m_fv[k] = v; end
        end
      end
    end
  endtask

  task automatic clear_faults();
    fault_s = '0; fault_c = '0; fault_p = '0; fault_g = '0;
  endtask

  task automatic set_fault(input int kind);
    clear_faults();
    if (kind == 1) begin
      fault_s[{1'b0, 4'd3, 4'd5}] = 1'b1;
      fault_s[{1'b1, 4'd3, 4'd5}] = 1'b1;
    end else if (kind == 2) begin
      fault_p = '1;
    end
  endtask

  task automatic random_faults();
    int idx;
    clear_faults();
    repeat ($urandom_range(0, 6)) begin
      idx = $urandom_range(0, NV - 1);
      case ($urandom_range(0, 3))
        0:       fault_s[idx] = 1'b1;
        1:       fault_c[idx] = 1'b1;
        2:       fault_p[idx] = 1'b1;
        default: fault_g[idx] = 1'b1;
      endcase
    end
  endtask

  task automatic do_run(input string name, input bit md, input logic [31:0] sd,
                        input logic [15:0] nv, input bit hold);
    bit finished = 1'b0;
    @(negedge clk);
    q0.delete(); q1.delete(); overlap = 0;
    mode = md; seed = sd; num_vec = nv; start = 1'b1; mon_en = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    // settings are captured with start; scramble them afterwards
    mode = ~md; seed = $urandom; num_vec = 16'($urandom);
    for (int c = 0; c < 4 * NV && !finished; c++) begin
      if (done0 && done1) finished = 1'b1;
      else @(negedge clk);
    end
    start = 1'b0; mon_en = 1'b0;
    check({name, "/finished"}, 64'(finished), 64'd1);
    $display("run %s: mode=%0b cycles=%0d err0=%0d err1=%0d fail_seen0=%0b fail_vec0=%03h fail_seen1=%0b fail_vec1=%03h",
             name, md, q0.size(), err_cnt0, err_cnt1, fail_seen0, fail_vec0, fail_seen1, fail_vec1);
  endtask

  task automatic check_seq(input string name);
    int bad0 = 0;
    int bad1 = 0;
    check({name, "/len0"}, 64'(q0.size()), 64'(exp_q.size()));
    check({name, "/len1"}, 64'(q1.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i >= q0.size() || q0[i] !== exp_q[i]) bad0++;
      if (i >= q1.size() || q1[i] !== exp_q[i]) bad1++;
    end
    check({name, "/seq0"}, 64'(bad0), 64'd0);
    check({name, "/seq1"}, 64'(bad1), 64'd0);
    check({name, "/overlap"}, 64'(overlap), 64'd0);
  endtask

  task automatic check_res(input string name, input int e0_err, input bit e0_fs, input logic [W-1:0] e0_fv,
                           input int e1_err, input bit e1_fs, input logic [W-1:0] e1_fv);
    check({name, "/done0"}, 64'(done0), 64'd1);
    check({name, "/busy0"}, 64'(busy0), 64'd0);
    check({name, "/done1"}, 64'(done1), 64'd1);
    check({name, "/err0"}, 64'(err_cnt0), 64'(e0_err));
    check({name, "/fs0"}, 64'(fail_seen0), 64'(e0_fs));
    check({name, "/fv0"}, 64'(fail_vec0), 64'(e0_fv));
    check({name, "/err1"}, 64'(err_cnt1), 64'(e1_err));
    check({name, "/fs1"}, 64'(fail_seen1), 64'(e1_fs));
    check({name, "/fv1"}, 64'(fail_vec1), 64'(e1_fv));
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "/busy0"}, 64'(busy0), 64'd0);
    check({name, "/done0"}, 64'(done0), 64'd0);
    check({name, "/err0"}, 64'(err_cnt0), 64'd0);
    check({name, "/fs0"}, 64'(fail_seen0), 64'd0);
    check({name, "/fv0"}, 64'(fail_vec0), 64'd0);
    check({name, "/vec0"}, 64'(v0), 64'd0);
    check({name, "/busy1"}, 64'(busy1), 64'd0);
    check({name, "/vec1"}, 64'(v1), 64'd0);
  endtask

  initial begin
    vec_t        tbl[4];
    int          cnt;
    bit          md;
    logic [31:0] sd;
    logic [15:0] nv;

    tbl[0] = '{"clean",      0, 1'b0, 0, 1'b0, 9'h000,   0, 1'b0, 9'h000};
    tbl[1] = '{"s_a3b5",     1, 1'b0, 2, 1'b1, 9'h035,   2, 1'b1, 9'h035};
    tbl[2] = '{"prop_inv",   2, 1'b0, 0, 1'b0, 9'h000, 512, 1'b1, 9'h000};
    tbl[3] = '{"hold_start", 0, 1'b1, 0, 1'b0, 9'h000,   0, 1'b0, 9'h000};

    // reset state
    #3;
    check_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle/busy0", 64'(busy0), 64'd0);

    // directed exhaustive runs; later rows start from DONE of the previous one
    for (int t = 0; t < 4; t++) begin
      set_fault(tbl[t].fault);
      build_exp(1'b0, 32'd0, 16'd0);
      do_run(tbl[t].name, 1'b0, 32'd0, 16'd0, tbl[t].hold);
      check({tbl[t].name, "/cycles"}, 64'(q0.size()), 64'd512);
      check_seq(tbl[t].name);
      check_res(tbl[t].name, tbl[t].e0_err, tbl[t].e0_fs, tbl[t].e0_fv,
                tbl[t].e1_err, tbl[t].e1_fs, tbl[t].e1_fv);
    end

    // in DONE, mismatches are ignored and the stimulus holds the last vector
    fault_s = '1; fault_p = '1;
    repeat (5) @(negedge clk);
    check("done_hold/err0", 64'(err_cnt0), 64'd0);
    check("done_hold/err1", 64'(err_cnt1), 64'd0);
    check("done_hold/fs0", 64'(fail_seen0), 64'd0);
    check("done_hold/vec0", 64'(v0), 64'h1FF);
    check("done_hold/done0", 64'(done0), 64'd1);
    $display("seq done_hold: err0=%0d vec0=%03h", err_cnt0, v0);

    // reset in the middle of a run discards everything, next run restarts at 0
    set_fault(1);
    @(negedge clk);
    mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 1000 && cnt < 100; c++) begin
      if (busy0) cnt++;
      if (cnt < 100) @(negedge clk);
    end
    check("midrun/reached", 64'(cnt), 64'd100);
    check("midrun/err0", 64'(err_cnt0), 64'd1);
    check("midrun/fv0", 64'(fail_vec0), 64'h035);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset/busy0", 64'(busy0), 64'd0);
    $display("seq midrun_reset: busy cycles before reset=%0d", cnt);
    build_exp(1'b0, 32'd0, 16'd0);
    model_results();
    do_run("restart", 1'b0, 32'd0, 16'd0, 1'b0);
    check_seq("restart");
    check_res("restart", 2, 1'b1, 9'h035, 2, 1'b1, 9'h035);

`ifdef ADDER_STIM_LFSR_EN
    // random mode with zero seed: seed replaced by 1
    clear_faults();
    build_exp(1'b1, 32'd0, 16'd10);
    model_results();
    do_run("lfsr_seed0", 1'b1, 32'd0, 16'd10, 1'b0);
    check("lfsr_seed0/first", 64'((q0.size() > 0) ? q0[0] : 9'h1FF), 64'h001);
    check("lfsr_seed0/cycles", 64'(q0.size()), 64'd10);
    check_seq("lfsr_seed0");
    check_res("lfsr_seed0", m_err[0], m_fs[0], m_fv[0], m_err[1], m_fs[1], m_fv[1]);

    // zero vector count behaves as one
    build_exp(1'b1, 32'hACE1, 16'd0);
    model_results();
    do_run("lfsr_num0", 1'b1, 32'hACE1, 16'd0, 1'b0);
    check("lfsr_num0/cycles", 64'(q0.size()), 64'd1);
    check_seq("lfsr_num0");
`endif

    // randomized runs against the behavioural model
    for (int r = 0; r < 6; r++) begin
      random_faults();
      md = 1'($urandom_range(0, 1));
      sd = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      nv = 16'($urandom_range(0, 40));
      build_exp(md, sd, nv);
      model_results();
      do_run($sformatf("rand%0d", r), md, sd, nv, 1'b0);
      check_seq($sformatf("rand%0d", r));
      check_res($sformatf("rand%0d", r), m_err[0], m_fs[0], m_fv[0], m_err[1], m_fs[1], m_fv[1]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/adder_stim_check.md
ADDER_STIM_CHECK -- requirements
Module: adder_stim_check

Interface
REQ-001 Parameter n, default 4, operand width; legal range 1..15.
REQ-002 Parameter type, default 0, 0 = compare s/cout only, 1 = also compare prop/gen.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  pulse; begins a test run from IDLE or DONE, ignored in RUN.
REQ-006 mode  input  1  0 = exhaustive sweep, 1 = LFSR random; sampled with start.
REQ-007 num_vec  input  16  random-mode vector count, sampled with start; 0 treated as 1.
REQ-008 seed  input  32  random-mode LFSR seed, sampled with start; 0 replaced by 32'h1.
REQ-009 cin, a, b  output  1, n, n  stimulus to reference adder and DUV, registered.
REQ-010 s_ref, s_duv  input  n each  sums returned by reference and DUV.
REQ-011 cout_ref, cout_duv, prop_ref, prop_duv, gen_ref, gen_duv  input  1 each  adder results.
REQ-012 busy  output  1  high in RUN.
REQ-013 done  output  1  high in DONE.
REQ-014 err_cnt  output  16  mismatching vectors in current run, saturating at 16'hFFFF.
REQ-015 fail_vec  output  2n+1  {cin,a,b} of first mismatching vector, valid when fail_seen=1.
REQ-016 fail_seen  output  1  at least one mismatch in current run.

Function
REQ-017 FSM states IDLE, RUN, DONE; start in IDLE or DONE -> RUN on next edge; RUN -> DONE after last vector checked; DONE holds until start.
REQ-018 On run start: err_cnt, fail_seen, fail_vec cleared; first vector driven in same edge.
REQ-019 Each vector held exactly one cycle; results checked on the edge that replaces it (results combinational of stimulus, zero-latency).
REQ-020 Mismatch = s_ref!=s_duv or cout_ref!=cout_duv, plus prop/gen inequality when type==1.
REQ-021 Exhaustive: {cin,a,b} = 2n+1-bit counter from 0 to 2^(2n+1)-1, increment by 1; RUN lasts exactly 2^(2n+1) cycles.
REQ-022 Random: 32-bit Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1, shift left, feedback into bit 0; {cin,a,b} = low 2n+1 bits; first vector = seed state; RUN lasts num_vec cycles.
REQ-023 Mismatch on last vector is counted before DONE asserts.
REQ-024 fail_vec captured only on the first mismatch of a run; later mismatches do not update it.
REQ-025 err_cnt saturates; no wrap.
REQ-026 In IDLE/DONE, cin/a/b hold last driven value; mismatches are ignored.
REQ-027 busy and done never high together; done remains high, results stable, until next start.

Reset
REQ-028 rst_n low: state IDLE, cin=0, a=0, b=0, busy=0, done=0, err_cnt=0, fail_vec=0, fail_seen=0, LFSR=32'h1, counters 0.
REQ-029 rst_n asserted mid-RUN aborts immediately to reset values; no partial results retained.

Configuration
REQ-030 Macro ADDER_STIM_LFSR_EN: defined -> random mode per REQ-022; undefined -> LFSR, seed and num_vec logic omitted, mode/seed/num_vec ignored, every run exhaustive.

Verification
REQ-031 n=4, type=0, DUV=ref, start mode=0 -> busy for 512 cycles, vectors 0..511 in order, done=1, err_cnt=0, fail_seen=0.
REQ-032 n=4, DUV s forced wrong when a=3,b=5 (both cin) -> err_cnt=2, fail_vec=9'h035, fail_seen=1.
REQ-033 type=1, prop_duv inverted for all vectors -> err_cnt=512; type=0 same fault -> err_cnt=0.
REQ-034 ADDER_STIM_LFSR_EN defined, mode=1, seed=0, num_vec=10 -> first vector = low 9 bits of 32'h1, 10 busy cycles, sequence matches model LFSR.
REQ-035 rst_n pulsed low at cycle 100 of exhaustive run -> all outputs reset values, IDLE; start then restarts from vector 0.
REQ-036 start held high throughout RUN -> ignored; start in DONE -> new run, err_cnt/fail_seen cleared.
